// File: rtl/miner_scheduler.sv
// Round/block sequencer for N double-SHA256 cores plus golden-nonce FIFO; registered outputs, one core checked per cycle.
// tx_valid/tx_ready handshake on the FIFO head; hits arriving while full with no pop are dropped and flagged.
module miner_scheduler #(
  parameter int NUM_CORES = 2,
  parameter int ROUNDS = 64,
  parameter int NONCE_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [NONCE_W-1:0] NONCE_START = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     work_valid,
  input  logic [255:0]             target,
  input  logic [NUM_CORES*256-1:0] hash_in,
  output logic [1:0]               block,
  output logic [6:0]               select,
  output logic [NONCE_W-1:0]       nonce_base,
  output logic                     busy,
  output logic                     exhausted,
  output logic [NONCE_W-1:0]       tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow,
  output logic [15:0]              hit_count
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [6:0] SEL_LAST = 7'(ROUNDS + 1);
  localparam logic [CW-1:0] LAST_CORE = CW'(NUM_CORES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, ADVANCE} state_t;

  state_t              state;
  logic [CW-1:0]       core_idx;
  logic [255:0]        cur_hash;
  logic [NONCE_W:0]    next_base;
  logic [NONCE_W-1:0]  push_dat;
  logic                hit, pop, full, push, drop;

  logic [NONCE_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  always_comb begin
    cur_hash = hash_in[255:0];
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_idx == CW'(i)) cur_hash = hash_in[256*i +: 256];
    end
  end

  // A restart in the same cycle as a check discards that check's hit.
  assign hit       = (state == CHECK) && (cur_hash < target) && !work_valid;
  assign pop       = tx_valid && tx_ready;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign push      = hit && (!full || pop);
  assign drop      = hit && full && !pop;
  assign push_dat  = nonce_base + NONCE_W'(core_idx);
  assign next_base = {1'b0, nonce_base} + (NONCE_W+1)'(NUM_CORES);

  assign busy     = (state != IDLE);
  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      hit_count <= '0;
    end else begin
      if (work_valid) overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
      if (push && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      block      <= '0;
      select     <= '0;
      nonce_base <= NONCE_START;
      exhausted  <= 1'b0;
      core_idx   <= '0;
    end else if (work_valid) begin
      state      <= RUN;
      block      <= '0;
      select     <= '0;
      nonce_base <= NONCE_START;
      exhausted  <= 1'b0;
      core_idx   <= '0;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (select == SEL_LAST) begin
            select <= '0;
            if (block == 2'd2) begin
              state    <= CHECK;
              core_idx <= '0;
            end else begin
              block <= block + 2'd1;
            end
          end else begin
            select <= select + 7'd1;
          end
        end
        CHECK: begin
          if (core_idx == LAST_CORE) state <= ADVANCE;
          else core_idx <= core_idx + CW'(1);
        end
        ADVANCE: begin
          // Carry out of the nonce adder means the nonce space is used up.
          if (next_base[NONCE_W]) begin
            exhausted <= 1'b1;
            state     <= IDLE;
          end else begin
            nonce_base <= next_base[NONCE_W-1:0];
            block      <= 2'd1;
            select     <= '0;
            state      <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_scheduler.sv
// Bench for miner_scheduler: compare-boundary table, hand sequences for timing/overflow/abort/reset/exhaustion, random run vs timeline model.
module tb_miner_scheduler;
  localparam int N = 2;
  localparam int R = 64;
  localparam int B = R + 2;
  localparam int D = 4;
  localparam int G1 = 3*B + N + 1;
  localparam int G = 2*B + N + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, work_valid, wv_ex, tx_ready;
  logic [255:0] target;
  logic [N*256-1:0] hash_in;
  logic [1:0] block, ex_block;
  logic [6:0] select, ex_select;
  logic [31:0] nonce_base, tx_data, ex_nonce_base, ex_tx_data;
  logic busy, exhausted, tx_valid, overflow;
  logic ex_busy, ex_exhausted, ex_tx_valid, ex_overflow;
  logic [15:0] hit_count, ex_hit_count;

  miner_scheduler #(.NUM_CORES(N), .ROUNDS(R), .NONCE_W(32), .FIFO_DEPTH(D), .NONCE_START(32'h0)) dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .target(target), .hash_in(hash_in),
    .block(block), .select(select), .nonce_base(nonce_base), .busy(busy), .exhausted(exhausted),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .overflow(overflow), .hit_count(hit_count));

  miner_scheduler #(.NUM_CORES(N), .ROUNDS(R), .NONCE_W(32), .FIFO_DEPTH(D), .NONCE_START(32'hFFFFFFFC)) u_ex (
    .clk(clk), .rst(rst), .work_valid(wv_ex), .target(target), .hash_in(hash_in),
    .block(ex_block), .select(ex_select), .nonce_base(ex_nonce_base), .busy(ex_busy), .exhausted(ex_exhausted),
    .tx_data(ex_tx_data), .tx_valid(ex_tx_valid), .tx_ready(tx_ready), .overflow(ex_overflow), .hit_count(ex_hit_count));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the work unit is a cycle count t.
  bit          m_active;
  int          m_t, m_blk, m_sel, m_hc;
  logic [31:0] m_base;
  bit          m_exh, m_ovf;
  logic [31:0] m_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind: 0 = rounds, 1 = checking core, 2 = advance
  task automatic phase_of(input int t, output int kind, output int blk, output int sel, output int core);
    int p;
    p = (t < G1) ? t : ((t - G1) % G + B);
    kind = 0; blk = 2; sel = 0; core = 0;
    if (p < 3*B) begin
      blk = p / B;
      sel = p % B;
    end else if (p < 3*B + N) begin
      kind = 1;
      core = p - 3*B;
    end else begin
      kind = 2;
    end
  endtask

  task automatic model_step(input logic r, input logic wv, input logic tr,
                            input logic [255:0] tg, input logic [N*256-1:0] h);
    int kind, blk, sel, core, had;
    bit pop, hit;
    if (r) begin
      m_active = 0; m_t = 0; m_base = 32'h0; m_exh = 0; m_ovf = 0; m_hc = 0;
      m_blk = 0; m_sel = 0;
      m_q.delete();
    end else begin
      kind = 0; core = 0; hit = 0; blk = 0; sel = 0;
      if (m_active) begin
        phase_of(m_t, kind, blk, sel, core);
        hit = (kind == 1) && !wv && (h[core*256 +: 256] < tg);
      end
      had = m_q.size();
      pop = (had > 0) && tr;
      if (pop) void'(m_q.pop_front());
      if (hit) begin
        if (had < D || pop) begin
          m_q.push_back(m_base + 32'(core));
          if (m_hc < 65535) m_hc++;
        end else begin
          m_ovf = 1;
        end
      end
      if (wv) begin
        m_active = 1; m_t = 0; m_base = 32'h0; m_exh = 0; m_ovf = 0;
      end else if (m_active) begin
        if (kind == 2) begin
          if ({1'b0, m_base} + 33'(N) > 33'hFFFFFFFF) begin
            m_exh = 1;
            m_active = 0;
          end else begin
            m_base = m_base + 32'(N);
            m_t++;
          end
        end else begin
          m_t++;
        end
      end
      if (m_active) begin
        phase_of(m_t, kind, blk, sel, core);
        m_blk = blk;
        m_sel = sel;
      end
    end
  endtask

  task automatic model_check();
    chk("m_block", 256'(block), 256'(m_blk));
    chk("m_select", 256'(select), 256'(m_sel));
    chk("m_nonce_base", 256'(nonce_base), 256'(m_base));
    chk("m_busy", 256'(busy), 256'(m_active));
    chk("m_exhausted", 256'(exhausted), 256'(m_exh));
    chk("m_overflow", 256'(overflow), 256'(m_ovf));
    chk("m_hit_count", 256'(hit_count), 256'(m_hc));
    chk("m_tx_valid", 256'(tx_valid), 256'(m_q.size() > 0));
    chk("m_tx_data", 256'(tx_data), (m_q.size() > 0) ? 256'(m_q[0]) : 256'h0);
  endtask

  task automatic tick();
    logic r, wv, tr;
    logic [255:0] tg;
    logic [N*256-1:0] h;
    r = rst; wv = work_valid; tr = tx_ready; tg = target; h = hash_in;
    @(posedge clk);
    model_step(r, wv, tr, tg, h);
    #1;
    model_check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [255:0] tgt;
    logic [255:0] h0;
    logic [255:0] h1;
    logic [1:0]   hits;
  } vec_t;

  vec_t tbl[7];
  logic [255:0] ones, tval, msb;

  initial begin
    ones = '1;
    msb  = 256'h1 << 255;
    tval = 256'h0123_4567_89AB_CDEF_0011_2233_4455_6677_8899_AABB_CCDD_EEFF_FEDC_BA98_7654_3211;
    tbl[0] = '{tgt: ones, h0: 256'h0,     h1: ones - 1,     hits: 2'b11};
    tbl[1] = '{tgt: 256'h0, h0: 256'h0,   h1: 256'h0,       hits: 2'b00};
    tbl[2] = '{tgt: tval, h0: tval,       h1: tval - 1,     hits: 2'b10};
    tbl[3] = '{tgt: tval, h0: tval + 1,   h1: tval,         hits: 2'b00};
    tbl[4] = '{tgt: msb,  h0: msb - 1,    h1: msb,          hits: 2'b01};
    tbl[5] = '{tgt: ones, h0: ones,       h1: 256'h0,       hits: 2'b10};
    tbl[6] = '{tgt: tval, h0: tval ^ 256'h1, h1: tval ^ msb, hits: 2'b01};

    rst = 1; work_valid = 0; wv_ex = 0; tx_ready = 0; target = '0; hash_in = '0;
    ticks(2);
    chk("rst_block", 256'(block), 256'h0);
    chk("rst_select", 256'(select), 256'h0);
    chk("rst_nonce_base", 256'(nonce_base), 256'h0);
    chk("rst_busy", 256'(busy), 256'h0);
    chk("rst_tx_valid", 256'(tx_valid), 256'h0);
    chk("rst_tx_data", 256'(tx_data), 256'h0);
    chk("rst_hit_count", 256'(hit_count), 256'h0);
    chk("rst_ex_nonce_base", 256'(ex_nonce_base), 256'hFFFFFFFC);
    rst = 0;

    // Compare boundaries, one nonce group each.
    for (int i = 0; i < 7; i++) begin
      target = tbl[i].tgt;
      hash_in = {tbl[i].h1, tbl[i].h0};
      work_valid = 1; tick(); work_valid = 0;
      ticks(201);
      for (int c = 0; c < N; c++) begin
        if (tbl[i].hits[c]) begin
          chk($sformatf("tbl%0d_valid", i), 256'(tx_valid), 256'h1);
          chk($sformatf("tbl%0d_data", i), 256'(tx_data), 256'(c));
          tx_ready = 1; tick(); tx_ready = 0;
        end
      end
      chk($sformatf("tbl%0d_empty", i), 256'(tx_valid), 256'h0);
    end

    // Group timing with no hits.
    target = '0; hash_in = '1;
    work_valid = 1; tick(); work_valid = 0;
    chk("t_blk0", 256'(block), 256'h0);
    ticks(66);  chk("t_blk1", 256'(block), 256'h1);
    ticks(66);  chk("t_blk2", 256'(block), 256'h2);
    ticks(69);  chk("t_g2_blk", 256'(block), 256'h1);
    chk("t_g2_base", 256'(nonce_base), 256'h2);
    ticks(65);  chk("t_g2_sel", 256'(select), 256'd65);
    tick();     chk("t_g2_blk2", 256'(block), 256'h2);
    ticks(69);  chk("t_g3_base", 256'(nonce_base), 256'h4);
    chk("t_g3_blk", 256'(block), 256'h1);
    chk("t_nohit", 256'(tx_valid), 256'h0);

    // First-push latency, FIFO fill and overflow.
    rst = 1; tick(); rst = 0;
    target = ones; hash_in = '0; tx_ready = 0;
    work_valid = 1; tick(); work_valid = 0;
    ticks(198); chk("lat_pre", 256'(tx_valid), 256'h0);
    tick();     chk("lat_valid", 256'(tx_valid), 256'h1);
    chk("lat_data", 256'(tx_data), 256'h0);
    tick();     chk("lat_hc", 256'(hit_count), 256'h2);
    tick();     chk("adv_base", 256'(nonce_base), 256'h2);
    ticks(267); chk("ovf_pre", 256'(overflow), 256'h0);
    chk("ovf_hc_pre", 256'(hit_count), 256'h4);
    tick();     chk("ovf_set", 256'(overflow), 256'h1);
    chk("ovf_hc", 256'(hit_count), 256'h4);
    tick();

    // Abort at block 1, select 30 with a full FIFO.
    ticks(31);
    chk("ab_pre_blk", 256'(block), 256'h1);
    chk("ab_pre_sel", 256'(select), 256'd30);
    work_valid = 1; tick(); work_valid = 0;
    chk("ab_blk", 256'(block), 256'h0);
    chk("ab_sel", 256'(select), 256'h0);
    chk("ab_base", 256'(nonce_base), 256'h0);
    chk("ab_ovf", 256'(overflow), 256'h0);
    chk("ab_head", 256'(tx_data), 256'h0);
    tx_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), 256'(tx_data), 256'(k));
      tick();
    end
    chk("drain_empty", 256'(tx_valid), 256'h0);

    // Reset during CHECK with a hit pending.
    ticks(194);
    chk("rc_blk", 256'(block), 256'h2);
    rst = 1; tick(); rst = 0;
    chk("rc_busy", 256'(busy), 256'h0);
    chk("rc_valid", 256'(tx_valid), 256'h0);
    chk("rc_hc", 256'(hit_count), 256'h0);
    chk("rc_blk0", 256'(block), 256'h0);

    // Nonce-space exhaustion on the high-start instance.
    tx_ready = 0; target = ones; hash_in = '0;
    wv_ex = 1; tick(); wv_ex = 0;
    ticks(201);
    chk("ex_base2", 256'(ex_nonce_base), 256'hFFFFFFFE);
    chk("ex_head", 256'(ex_tx_data), 256'hFFFFFFFC);
    ticks(134);
    chk("ex_busy_pre", 256'(ex_busy), 256'h1);
    chk("ex_exh_pre", 256'(ex_exhausted), 256'h0);
    tick();
    chk("ex_exh", 256'(ex_exhausted), 256'h1);
    chk("ex_busy", 256'(ex_busy), 256'h0);
    chk("ex_base", 256'(ex_nonce_base), 256'hFFFFFFFE);
    chk("ex_hc", 256'(ex_hit_count), 256'h4);
    ticks(5);
    chk("ex_idle", 256'(ex_busy), 256'h0);

    // Random traffic against the model.
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      work_valid = (i == 0) || ($urandom_range(0, 299) == 0);
      if (work_valid) target = rand256();
      hash_in = {rand256(), rand256()};
      tx_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
